// File: rtl/mic_frame_buf.sv
// Ping-pong frame buffer: captures receiver samples into two banks of FRAME_LEN
// and streams each completed frame out over valid/ready, flagging dropped samples.
module mic_frame_buf #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          dout_last,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    full;
    logic          wr_bank;
    logic [AW-1:0] wr_idx;
    logic          rd_bank;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] mem [2*FRAME_LEN];

    logic wr_en;
    logic drop;
    logic wr_done;
    logic rd_xfer;
    logic rd_done;

    assign wr_en   = din_vld && !full[wr_bank];
    assign drop    = din_vld && full[wr_bank];
    assign wr_done = wr_en && (wr_idx == LAST_IDX);
    assign rd_xfer = dout_vld && dout_rdy;
    assign rd_done = rd_xfer && dout_last;

    // Bank number is the MSB of the flat storage address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (wr_en) begin
            if (wr_done) begin
                wr_bank <= ~wr_bank;
                wr_idx  <= '0;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Completing a frame and freeing a bank in one cycle always hit different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && full[rd_bank]) begin
                rd_idx <= '0;
            end else if (rd_xfer) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        dout_vld  = 1'b0;
        dout      = '0;
        dout_last = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                dout_vld  = 1'b1;
                dout      = mem[{rd_bank, rd_idx}];
                dout_last = (rd_idx == LAST_IDX);
                if (rd_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mic_frame_buf.sv
// Directed bench for mic_frame_buf with FRAME_LEN=4: reset, streaming,
// backpressure, overflow, drop/clear race and mid-stream reset.
module tb_mic_frame_buf;

    localparam int DW = 16;
    localparam int FL = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_vld;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy;
    logic          dout_last;
    logic          ovf;
    logic          ovf_clr;

    int checks;
    int failures;

    mic_frame_buf #(.DW(DW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_last (dout_last),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            din     = base + DW'(i);
            din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din      = DW'($urandom);
            din_vld  = 1'($urandom_range(0, 1));
            dout_rdy = 1'($urandom_range(0, 1));
            ovf_clr  = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (dout !== '0 || dout_vld !== 1'b0 || dout_last !== 1'b0 || ovf !== 1'b0) begin
                $display("[TB] FAIL reset_outputs: dout=%h vld=%b last=%b ovf=%b required all 0",
                         dout, dout_vld, dout_last, ovf);
                failures++;
            end
        end
        din_vld  = 1'b0;
        dout_rdy = 1'b1;
        ovf_clr  = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dout_vld !== 1'b0 || ovf !== 1'b0) begin
                $display("[TB] FAIL reset_idle: vld=%b ovf=%b required 0 0", dout_vld, ovf);
                failures++;
            end
        end
    endtask

    task automatic test_single_frame();
        dout_rdy = 1'b1;
        send_frame(16'h0001, FL);
        checks++;
        if (dout_vld !== 1'b0) begin
            $display("[TB] FAIL single_latency_t1: vld=%b required 0", dout_vld);
            failures++;
        end
        tick();
        for (int k = 0; k < FL; k++) begin
            checks++;
            if (dout_vld !== 1'b1 || dout !== DW'(k + 1) || dout_last !== (k == FL - 1)) begin
                $display("[TB] FAIL single_data[%0d]: vld=%b dout=%h last=%b required 1 %h %b",
                         k, dout_vld, dout, dout_last, DW'(k + 1), (k == FL - 1));
                failures++;
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dout_vld !== 1'b0) begin
                $display("[TB] FAIL single_after: vld=%b required 0", dout_vld);
                failures++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int            exp_idx;
        int            cyc;
        logic          stalled;
        logic [DW-1:0] held;
        logic          held_last;
        exp_idx  = 0;
        stalled  = 1'b0;
        held     = '0;
        held_last = 1'b0;
        dout_rdy = 1'b0;
        send_frame(16'hA000, FL);
        cyc = 0;
        while (exp_idx < FL && cyc < 80) begin
            dout_rdy = ((cyc % 3) == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            #0;
            if (stalled) begin
                checks++;
                if (dout_vld !== 1'b1 || dout !== held || dout_last !== held_last) begin
                    $display("[TB] FAIL bp_stable: vld=%b dout=%h last=%b required 1 %h %b",
                             dout_vld, dout, dout_last, held, held_last);
                    failures++;
                end
            end
            if (dout_vld === 1'b1) begin
                checks++;
                if (dout !== 16'hA000 + DW'(exp_idx) || dout_last !== (exp_idx == FL - 1)) begin
                    $display("[TB] FAIL bp_data[%0d]: dout=%h last=%b required %h %b",
                             exp_idx, dout, dout_last, 16'hA000 + DW'(exp_idx), (exp_idx == FL - 1));
                    failures++;
                end
                stalled   = !dout_rdy;
                held      = dout;
                held_last = dout_last;
                if (dout_rdy) exp_idx++;
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        checks++;
        if (exp_idx != FL) begin
            $display("[TB] FAIL bp_timeout: received=%0d required %0d", exp_idx, FL);
            failures++;
        end
        checks++;
        if (dout_vld !== 1'b0) begin
            $display("[TB] FAIL bp_after: vld=%b required 0", dout_vld);
            failures++;
        end
    endtask

    task automatic test_overflow();
        dout_rdy = 1'b0;
        send_frame(16'h0001, 2 * FL);
        checks++;
        if (ovf !== 1'b0) begin
            $display("[TB] FAIL ovf_before_drop: ovf=%b required 0", ovf);
            failures++;
        end
        din     = 16'h0009;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            $display("[TB] FAIL ovf_set: ovf=%b required 1", ovf);
            failures++;
        end
        checks++;
        if (dout_vld !== 1'b1 || dout !== 16'h0001) begin
            $display("[TB] FAIL ovf_stall_head: vld=%b dout=%h required 1 0001", dout_vld, dout);
            failures++;
        end
        dout_rdy = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                checks++;
                if (dout_vld !== 1'b1 || dout !== DW'(f * FL + k + 1) || dout_last !== (k == FL - 1)) begin
                    $display("[TB] FAIL ovf_drain[%0d]: vld=%b dout=%h last=%b required 1 %h %b",
                             f * FL + k, dout_vld, dout, dout_last, DW'(f * FL + k + 1), (k == FL - 1));
                    failures++;
                end
                tick();
            end
            checks++;
            if (dout_vld !== 1'b0 || ovf !== 1'b1) begin
                $display("[TB] FAIL ovf_gap[%0d]: vld=%b ovf=%b required 0 1", f, dout_vld, ovf);
                failures++;
            end
            tick();
        end
        checks++;
        if (dout_vld !== 1'b0) begin
            $display("[TB] FAIL ovf_sample9_dropped: vld=%b required 0", dout_vld);
            failures++;
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            $display("[TB] FAIL ovf_clear: ovf=%b required 0", ovf);
            failures++;
        end
    endtask

    task automatic test_drop_clear_race();
        dout_rdy = 1'b0;
        send_frame(16'h0010, 2 * FL);
        din     = 16'h00FF;
        din_vld = 1'b1;
        ovf_clr = 1'b1;
        tick();
        din_vld = 1'b0;
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            $display("[TB] FAIL race_set_wins: ovf=%b required 1", ovf);
            failures++;
        end
        tick();
        checks++;
        if (ovf !== 1'b1) begin
            $display("[TB] FAIL race_sticky: ovf=%b required 1", ovf);
            failures++;
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            $display("[TB] FAIL race_clear_alone: ovf=%b required 0", ovf);
            failures++;
        end
    endtask

    task automatic test_reset_midstream();
        dout_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout_vld !== 1'b1 || dout !== DW'(16'h0010 + k)) begin
                $display("[TB] FAIL mid_pre[%0d]: vld=%b dout=%h required 1 %h",
                         k, dout_vld, dout, DW'(16'h0010 + k));
                failures++;
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout_vld !== 1'b0 || dout !== '0 || dout_last !== 1'b0) begin
            $display("[TB] FAIL mid_reset_immediate: vld=%b dout=%h last=%b required 0 0 0",
                     dout_vld, dout, dout_last);
            failures++;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (dout_vld !== 1'b0) begin
            $display("[TB] FAIL mid_after_release: vld=%b required 0", dout_vld);
            failures++;
        end
        send_frame(16'h0055, FL);
        tick();
        for (int k = 0; k < FL; k++) begin
            checks++;
            if (dout_vld !== 1'b1 || dout !== DW'(16'h0055 + k) || dout_last !== (k == FL - 1)) begin
                $display("[TB] FAIL mid_fresh[%0d]: vld=%b dout=%h last=%b required 1 %h %b",
                         k, dout_vld, dout, dout_last, DW'(16'h0055 + k), (k == FL - 1));
                failures++;
            end
            tick();
        end
        checks++;
        if (dout_vld !== 1'b0) begin
            $display("[TB] FAIL mid_fresh_end: vld=%b required 0", dout_vld);
            failures++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        din      = '0;
        din_vld  = 1'b0;
        dout_rdy = 1'b0;
        ovf_clr  = 1'b0;
        #1;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_drop_clear_race();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
